timers_timer2_psc: RTL and testbench

Phase/sync controller that sequences timers_timer2_acg from the crank toothed-wheel input (default 60-2).
- Conditions the raw tooth signal and measures tooth periods.
- Locates the missing-tooth gap and maintains angular sync.
- Drives the ACG phase pulse (pdf_pht) and the run enable (tcon2 TR2).
- Reports sync status, tooth index, revolution pulse and errors to the SFR block.

---
 rtl/timers_timer2_psc.sv | 215 +++++++++++++++++++++
 tb/tb_timers_timer2_psc.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/timers_timer2_psc.sv
`default_nettype none
// ============================================================================
// Module   : timers_timer2_psc
// Purpose  : Crank-wheel phase/sync controller; finds the missing-tooth gap
//            and sequences timers_timer2_acg (pdf_pht pulse, TR2 run enable).
// Options  : TIMERS_TIMER2_PSC_FILTER_EN adds a FILT_LEN-sample glitch filter.
// Revision : 1.0 - initial release
// ============================================================================
module timers_timer2_psc #(
    parameter int PER_W   = 16,
    parameter int TEETH   = 60,
    parameter int MISSING = 2
`ifdef TIMERS_TIMER2_PSC_FILTER_EN
    ,
    parameter int FILT_LEN = 4
`endif
) (
    input  logic             timers_timer2_psc_clock_i,
    input  logic             timers_timer2_psc_reset_i,
    input  logic             timers_timer2_psc_en_i,
    input  logic             timers_timer2_psc_tooth_i,
    input  logic             timers_timer2_psc_errclr_i,
    output logic             timers_timer2_acg_pdf_pht_o,
    output logic             timers_sfr_tcon2_tr2_o,
    output logic             timers_timer2_psc_sync_o,
    output logic             timers_timer2_psc_rev_o,
    output logic [7:0]       timers_timer2_psc_tooth_cnt_o,
    output logic [PER_W-1:0] timers_timer2_psc_period_o,
    output logic             timers_timer2_psc_err_o
);

    localparam logic [7:0]       c_last_tooth = 8'(TEETH - MISSING - 1);
    localparam logic [PER_W-1:0] c_per_max    = '1;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WAIT_FIRST = 3'd1,
        S_WAIT_PER   = 3'd2,
        S_WAIT_GAP   = 3'd3,
        S_SYNC       = 3'd4
    } state_t;

    logic clk;
    logic rst;
    assign clk = timers_timer2_psc_clock_i;
    assign rst = timers_timer2_psc_reset_i;

    logic             r_sync1, r_sync2, r_lvl_d, r_edge;
    logic             w_lvl;
    logic [PER_W-1:0] r_per_cnt, r_prev;
    logic [PER_W:0]   w_thr;
    logic             w_gap, w_timeout;
    state_t           r_state, w_state_nxt;
    logic [7:0]       r_tooth_cnt, w_cnt_nxt;
    logic             r_pht, r_rev, r_run, r_err;
    logic             w_pht_nxt, w_rev_nxt, w_err_set, w_prev_ld;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= timers_timer2_psc_tooth_i;
            r_sync2 <= r_sync1;
        end
    end

`ifdef TIMERS_TIMER2_PSC_FILTER_EN
    localparam int c_fcnt_w = $clog2(FILT_LEN) + 1;
    logic [c_fcnt_w-1:0] r_fcnt;
    logic                r_filt;

    // Level only follows the input after FILT_LEN consecutive differing samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fcnt <= '0;
            r_filt <= 1'b0;
        end else if (r_sync2 == r_filt) begin
            r_fcnt <= '0;
        end else if (r_fcnt == c_fcnt_w'(FILT_LEN - 1)) begin
            r_fcnt <= '0;
            r_filt <= r_sync2;
        end else begin
            r_fcnt <= r_fcnt + c_fcnt_w'(1);
        end
    end
    assign w_lvl = r_filt;
`else
    assign w_lvl = r_sync2;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lvl_d <= 1'b0;
            r_edge  <= 1'b0;
        end else begin
            r_lvl_d <= w_lvl;
            r_edge  <= w_lvl & ~r_lvl_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_per_cnt <= '0;
        end else if (!timers_timer2_psc_en_i) begin
            r_per_cnt <= '0;
        end else if (r_edge) begin
            r_per_cnt <= PER_W'(1);
        end else if (!w_timeout) begin
            r_per_cnt <= r_per_cnt + PER_W'(1);
        end
    end

    // One extra bit so prev + prev/2 cannot wrap for long periods.
    assign w_thr     = {1'b0, r_prev} + {2'b00, r_prev[PER_W-1:1]};
    assign w_gap     = ({1'b0, r_per_cnt} > w_thr);
    assign w_timeout = (r_per_cnt == c_per_max);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_tooth_cnt;
        w_pht_nxt   = 1'b0;
        w_rev_nxt   = 1'b0;
        w_err_set   = 1'b0;
        w_prev_ld   = 1'b0;
        if (!timers_timer2_psc_en_i) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                S_IDLE: w_state_nxt = S_WAIT_FIRST;
                S_WAIT_FIRST: begin
                    if (r_edge) w_state_nxt = S_WAIT_PER;
                end
                S_WAIT_PER: begin
                    if (r_edge) begin
                        w_prev_ld   = 1'b1;
                        w_state_nxt = S_WAIT_GAP;
                    end
                end
                S_WAIT_GAP: begin
                    if (r_edge) begin
                        if (w_gap) begin
                            w_cnt_nxt   = '0;
                            w_pht_nxt   = 1'b1;
                            w_rev_nxt   = 1'b1;
                            w_state_nxt = S_SYNC;
                        end else begin
                            w_prev_ld = 1'b1;
                        end
                    end else if (w_timeout) begin
                        w_state_nxt = S_WAIT_FIRST;
                    end
                end
                S_SYNC: begin
                    if (r_edge) begin
                        w_prev_ld = ~w_gap;
                        if (r_tooth_cnt < c_last_tooth && !w_gap) begin
                            w_cnt_nxt = r_tooth_cnt + 8'd1;
                            w_pht_nxt = 1'b1;
                        end else if (r_tooth_cnt == c_last_tooth && w_gap) begin
                            w_cnt_nxt = '0;
                            w_pht_nxt = 1'b1;
                            w_rev_nxt = 1'b1;
                        end else begin
                            // Gap in the wrong place: drop sync, hunt for the next gap.
                            w_err_set   = 1'b1;
                            w_cnt_nxt   = '0;
                            w_state_nxt = S_WAIT_GAP;
                        end
                    end else if (w_timeout) begin
                        w_err_set   = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_WAIT_FIRST;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tooth_cnt <= '0;
            r_pht       <= 1'b0;
            r_rev       <= 1'b0;
            r_run       <= 1'b0;
            r_err       <= 1'b0;
            r_prev      <= '0;
        end else begin
            r_tooth_cnt <= w_cnt_nxt;
            r_pht       <= w_pht_nxt;
            r_rev       <= w_rev_nxt;
            r_run       <= (w_state_nxt == S_SYNC);
            if (w_err_set)                       r_err <= 1'b1;
            else if (timers_timer2_psc_errclr_i) r_err <= 1'b0;
            if (w_prev_ld) r_prev <= r_per_cnt;
        end
    end

    assign timers_timer2_acg_pdf_pht_o   = r_pht;
    assign timers_sfr_tcon2_tr2_o        = r_run;
    assign timers_timer2_psc_sync_o      = r_run;
    assign timers_timer2_psc_rev_o       = r_rev;
    assign timers_timer2_psc_tooth_cnt_o = r_tooth_cnt;
    assign timers_timer2_psc_period_o    = r_prev;
    assign timers_timer2_psc_err_o       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_timers_timer2_psc.sv
`default_nettype none
// ============================================================================
// Module   : tb_timers_timer2_psc
// Purpose  : Self-checking bench for timers_timer2_psc on a 60-2 crank wheel.
// Revision : 1.0 - initial release
// ============================================================================
module tb_timers_timer2_psc;

`ifdef TIMERS_TIMER2_PSC_FILTER_EN
    localparam int LAT = 8;
`else
    localparam int LAT = 4;
`endif

    logic        clk = 1'b0;
    logic        rst, en, tooth, errclr;
    logic        pht, tr2, sync, rev, err;
    logic [7:0]  tcnt;
    logic [15:0] period;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;
    int n_pht  = 0;
    int n_rev  = 0;

    typedef struct {int cyc; int cnt; bit rev;} exp_t;
    typedef struct {int interval; bit pulse; int cnt; bit rev;} tooth_t;
    exp_t   sb[$];
    tooth_t tbl[$];

    timers_timer2_psc dut (
        .timers_timer2_psc_clock_i     (clk),
        .timers_timer2_psc_reset_i     (rst),
        .timers_timer2_psc_en_i        (en),
        .timers_timer2_psc_tooth_i     (tooth),
        .timers_timer2_psc_errclr_i    (errclr),
        .timers_timer2_acg_pdf_pht_o   (pht),
        .timers_sfr_tcon2_tr2_o        (tr2),
        .timers_timer2_psc_sync_o      (sync),
        .timers_timer2_psc_rev_o       (rev),
        .timers_timer2_psc_tooth_cnt_o (tcnt),
        .timers_timer2_psc_period_o    (period),
        .timers_timer2_psc_err_o       (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input int cnt, input bit rv);
        exp_t e;
        e.cyc = cyc + LAT;
        e.cnt = cnt;
        e.rev = rv;
        sb.push_back(e);
    endtask

    // One tooth: rise now, next rise 'interval' clocks later.
    task automatic drive_tooth(input int interval, input bit pulse, input int cnt, input bit rv);
        int hi;
        hi = (interval >= 10) ? 5 : interval / 2;
        tooth = 1'b1;
        if (pulse) push_exp(cnt, rv);
        repeat (hi) @(negedge clk);
        tooth = 1'b0;
        repeat (interval - hi) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pht"},    int'(pht),    0);
        check({tag, "_tr2"},    int'(tr2),    0);
        check({tag, "_sync"},   int'(sync),   0);
        check({tag, "_rev"},    int'(rev),    0);
        check({tag, "_tcnt"},   int'(tcnt),   0);
        check({tag, "_period"}, int'(period), 0);
        check({tag, "_err"},    int'(err),    0);
    endtask

    // Scoreboard: every pdf_pht pulse must match the oldest expected tooth.
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            e = sb.pop_front();
            check("missed_pht_cycle", cyc, e.cyc);
        end
        if (pht) begin
            n_pht++;
            if (sb.size() == 0) begin
                check("unexpected_pht", 1, 0);
            end else begin
                e = sb.pop_front();
                check("pht_cycle", cyc, e.cyc);
                check("pht_tooth_cnt", int'(tcnt), e.cnt);
                check("pht_rev", int'(rev), int'(e.rev));
            end
        end
        if (rev) begin
            n_rev++;
            check("rev_with_pht", int'(pht), 1);
        end
    end

    initial begin
        int t_rise;
        bit found;
        rst = 1'b1; en = 1'b0; tooth = 1'b0; errclr = 1'b0;

        // Two teeth, gap, then two full revolutions ending on tooth 0.
        tbl.push_back('{10, 1'b0, 0, 1'b0});
        tbl.push_back('{30, 1'b0, 0, 1'b0});
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 58; i++)
                tbl.push_back('{(i == 57) ? 30 : 10, 1'b1, i, (i == 0)});
        tbl.push_back('{10, 1'b1, 0, 1'b1});

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        en  = 1'b1;
        repeat (3) @(negedge clk);

        for (int k = 0; k < tbl.size(); k++) begin
            drive_tooth(tbl[k].interval, tbl[k].pulse, tbl[k].cnt, tbl[k].rev);
            if (k == 2) begin
                check("acq_sync", int'(sync), 1);
                check("acq_tr2", int'(tr2), 1);
                check("acq_period", int'(period), 10);
                check("acq_tcnt", int'(tcnt), 0);
                check("acq_err", int'(err), 0);
            end
        end
        check("steady_pht_count", n_pht, 117);
        check("steady_rev_count", n_rev, 3);
        check("steady_err", int'(err), 0);

`ifdef TIMERS_TIMER2_PSC_FILTER_EN
        tooth = 1'b1;
        repeat (2) @(negedge clk);
        tooth = 1'b0;
        repeat (3) @(negedge clk);
`endif
        // Extra tooth half-way through the gap.
        for (int i = 1; i <= 56; i++) drive_tooth(10, 1'b1, i, 1'b0);
        drive_tooth(15, 1'b1, 57, 1'b0);
        check("pre_extra_pht_count", n_pht, 174);
        drive_tooth(15, 1'b0, 0, 1'b0);
        check("extra_err", int'(err), 1);
        check("extra_sync", int'(sync), 0);
        check("extra_tr2", int'(tr2), 0);
        check("extra_tcnt", int'(tcnt), 0);
        drive_tooth(10, 1'b0, 0, 1'b0);
        for (int i = 1; i <= 56; i++) drive_tooth(10, 1'b0, 0, 1'b0);
        drive_tooth(30, 1'b0, 0, 1'b0);
        drive_tooth(10, 1'b1, 0, 1'b1);
        check("resync_sync", int'(sync), 1);
        check("resync_err_sticky", int'(err), 1);
        errclr = 1'b1;
        @(negedge clk);
        errclr = 1'b0;
        check("errclr", int'(err), 0);

        // Enable dropped at tooth 20.
        for (int i = 1; i <= 20; i++) drive_tooth(10, 1'b1, i, 1'b0);
        en = 1'b0;
        @(negedge clk);
        check("endrop_sync", int'(sync), 0);
        check("endrop_tr2", int'(tr2), 0);
        check("endrop_tcnt", int'(tcnt), 0);
        check("endrop_period_held", int'(period), 10);
        check("endrop_err", int'(err), 0);
        repeat (3) @(negedge clk);
        en = 1'b1;
        repeat (3) @(negedge clk);

        // Re-sync, then stall with the tooth input held low.
        drive_tooth(10, 1'b0, 0, 1'b0);
        drive_tooth(30, 1'b0, 0, 1'b0);
        t_rise = cyc;
        drive_tooth(10, 1'b1, 0, 1'b1);
        check("stall_pre_sync", int'(sync), 1);
        found = 1'b0;
        for (int w = 0; w < 70000; w++) begin
            if (err) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("stall_timeout_seen", int'(found), 1);
        if (found) check("stall_err_cycle", cyc - t_rise, LAT + 65535);
        check("stall_tr2", int'(tr2), 0);
        check("stall_sync", int'(sync), 0);

        // Async reset mid-period while synced.
        drive_tooth(10, 1'b0, 0, 1'b0);
        drive_tooth(30, 1'b0, 0, 1'b0);
        drive_tooth(10, 1'b1, 0, 1'b1);
        check("prereset_sync", int'(sync), 1);
        tooth = 1'b1;
        push_exp(1, 1'b0);
        repeat (LAT + 2) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_all_zero("async_reset");
        @(negedge clk);
        rst   = 1'b0;
        tooth = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 3; i++) drive_tooth(10, 1'b0, 0, 1'b0);
        check("postreset_sync", int'(sync), 0);
        check("postreset_tcnt", int'(tcnt), 0);

        repeat (LAT + 4) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
